// File: rtl/ifu_pkg.sv
// Shared types for the LemonPC prefetching fetch unit: FSM states, reset PC and FIFO entry layout.
// Entry fields are sized for the widest supported build (XLEN<=64, ILEN<=32); narrower builds use the low bits.
package ifu_pkg;

  typedef enum logic {
    IFU_REQ  = 1'b0,
    IFU_WAIT = 1'b1
  } ifu_state_t;

  localparam logic [63:0] IFU_PC_INIT = 64'h8000_0000;
  localparam int          IFU_PC_W    = 64;
  localparam int          IFU_INST_W  = 32;

  typedef struct packed {
    logic [IFU_PC_W-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO, DEPTH a power of two. Read data is the registered head entry (no fall-through).
// Flush beats push and pop. Push while full is dropped unless a pop happens in the same cycle.
module ifu_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled fetch: one outstanding word request, DEPTH-entry prefetch FIFO to decode; IFU_BYPASS_EN adds an empty-FIFO bypass.
// Response-to-inst_valid is 1 cycle (0 with bypass); requests are only issued with a free FIFO slot, so decode stalls never overflow.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int          XLEN    = 64,
  parameter int          ILEN    = 32,
  parameter int          DEPTH   = 4,
  parameter logic [63:0] PC_INIT = IFU_PC_INIT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);

  localparam int CNT_W = $clog2(DEPTH+1);

  ifu_state_t       state;
  ifu_state_t       state_nxt;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             drop;

  logic             req_fire;
  logic             resp_take;
  logic             resp_push;
  logic             bypass;
  logic             pop_fire;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  ifu_entry_t       wr_entry;
  ifu_entry_t       rd_entry;

  assign req_addr = fetch_pc;
  assign req_fire = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IFU_REQ;
      fetch_pc <= PC_INIT[XLEN-1:0];
      req_pc   <= '0;
      drop     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid)  fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)   fetch_pc <= fetch_pc + XLEN'(4);
      // A redirect leaves exactly one stale response in flight unless it lands this very cycle.
      if (redirect_valid)  drop <= (state == IFU_WAIT) ? !resp_valid : req_fire;
      else if (resp_take)  drop <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    resp_take = 1'b0;
    case (state)
      IFU_REQ: begin
        req_valid = !rst && !halt && (fifo_count < CNT_W'(DEPTH));
        if (req_valid && req_ready) state_nxt = IFU_WAIT;
      end
      IFU_WAIT: begin
        resp_take = resp_valid;
        if (resp_valid) state_nxt = IFU_REQ;
      end
      default: state_nxt = IFU_REQ;
    endcase
  end

  always_comb begin
    resp_push = resp_take && !drop && !redirect_valid;
`ifdef IFU_BYPASS_EN
    bypass = fifo_empty && resp_push;
`else
    bypass = 1'b0;
`endif
    fifo_push              = resp_push && !(bypass && inst_ready) && (!fifo_full || pop_fire);
    wr_entry               = '0;
    wr_entry.pc[XLEN-1:0]  = req_pc;
    wr_entry.inst[ILEN-1:0] = resp_data;
    inst_valid             = !fifo_empty || bypass;
    pop_fire               = !fifo_empty && inst_ready;
    inst                   = bypass ? resp_data : rd_entry.inst[ILEN-1:0];
    inst_pc                = bypass ? req_pc    : rd_entry.pc[XLEN-1:0];
  end

  ifu_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wr_entry),
    .pop       (pop_fire),
    .flush     (redirect_valid),
    .pop_data  (rd_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: sequential fetch, FIFO fill/backpressure, redirects, halt, reset abort, PC wrap, bypass.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request/response pair with 1-cycle memory latency; decode held off.
  task automatic issue(input logic [63:0] addr, input logic [31:0] data);
    req_ready = 1'b1;
    #1;
    check("req_valid", req_valid, 1);
    check("req_addr", req_addr, addr);
    step();
    req_ready = 1'b0;
    check("wait_no_req", req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = data;
    step();
    resp_valid = 1'b0;
    #1;
  endtask

  task automatic beat(input logic [63:0] addr, input logic [31:0] data);
    issue(addr, data);
    check("inst_valid", inst_valid, 1);
    check("inst_pc", inst_pc, addr);
    check("inst", inst, data);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("popped_empty", inst_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] drain_pc [4];
    drain_pc = '{64'h8000_0010, 64'h8000_0014, 64'h8000_0018, 64'h8000_001C};

    rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    step();
    step();
    check("rst_req_valid", req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    rst = 1'b0;

    // Sequential fetch from PC_INIT
    beat(64'h8000_0000, 32'h1111_0000);
    beat(64'h8000_0004, 32'h1111_0004);
    beat(64'h8000_0008, 32'h1111_0008);

    // Fill the FIFO with decode stalled
    issue(64'h8000_000C, 32'h2222_000C);
    issue(64'h8000_0010, 32'h2222_0010);
    issue(64'h8000_0014, 32'h2222_0014);
    issue(64'h8000_0018, 32'h2222_0018);
    check("full_no_req", req_valid, 0);
    check("full_inst_valid", inst_valid, 1);
    check("full_head_pc", inst_pc, 64'h8000_000C);
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold", req_valid, 0);
    end
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    issue(64'h8000_001C, 32'h2222_001C);
    check("refull_no_req", req_valid, 0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", inst_pc, drain_pc[i]);
      step();
    end
    inst_ready = 1'b0;
    check("drained", inst_valid, 0);

    // Redirect while waiting: flush FIFO and drop the in-flight response
    issue(64'h8000_0020, 32'h3333_0020);
    req_ready = 1'b1;
    #1;
    check("pre_redir_addr", req_addr, 64'h8000_0024);
    step();
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("redir_flush", inst_valid, 0);
    check("redir_wait", req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_0024;
    step();
    resp_valid = 1'b0;
    check("redir_dropped", inst_valid, 0);
    check("redir_req", req_valid, 1);
    check("redir_addr", req_addr, 64'h8000_0100);

    // Redirect in REQ without handshake, then coincident with a handshake
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0010;
    step();
    redirect_valid = 1'b0;
    check("redir_req_only", req_addr, 64'h8000_0010);
    req_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0203;
    step();
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    check("coinc_wait", req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_0010;
    step();
    resp_valid = 1'b0;
    check("coinc_dropped", inst_valid, 0);
    check("coinc_addr", req_addr, 64'h8000_0200);
    beat(64'h8000_0200, 32'h4444_0200);

    // Halt while waiting: pending response delivered, no new requests
    req_ready = 1'b1;
    #1;
    check("halt_pre_addr", req_addr, 64'h8000_0204);
    step();
    req_ready  = 1'b0;
    halt       = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h5555_0204;
    step();
    resp_valid = 1'b0;
    check("halt_deliver", inst_valid, 1);
    check("halt_pc", inst_pc, 64'h8000_0204);
    check("halt_no_req", req_valid, 0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt_hold", req_valid, 0);
      step();
    end
    halt = 1'b0;
    #1;
    check("resume_req", req_valid, 1);
    beat(64'h8000_0208, 32'h5555_0208);

    // Reset while waiting: late response ignored, restart at PC_INIT
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    check("rst_mid_req", req_valid, 0);
    rst        = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hBAD0_020C;
    step();
    resp_valid = 1'b0;
    check("rst_late_resp", inst_valid, 0);
    check("rst_restart_req", req_valid, 1);
    check("rst_restart_addr", req_addr, 64'h8000_0000);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = '1;
    step();
    redirect_valid = 1'b0;
    check("wrap_align", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    beat(64'hFFFF_FFFF_FFFF_FFFC, 32'h6666_FFFC);
    check("wrap_zero", req_addr, 64'h0);

    // Response into an empty FIFO with decode ready
    req_ready = 1'b1;
    step();
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'hCAFE_0000;
    #1;
`ifdef IFU_BYPASS_EN
    check("byp_same_cycle", inst_valid, 1);
    check("byp_pc", inst_pc, 64'h0);
    check("byp_inst", inst, 32'hCAFE_0000);
`else
    check("nobyp_same_cycle", inst_valid, 0);
`endif
    step();
    resp_valid = 1'b0;
    #1;
`ifdef IFU_BYPASS_EN
    check("byp_not_pushed", inst_valid, 0);
`else
    check("nobyp_next_cycle", inst_valid, 1);
    check("nobyp_pc", inst_pc, 64'h0);
    check("nobyp_inst", inst, 32'hCAFE_0000);
`endif
    step();
    inst_ready = 1'b0;
    check("final_empty", inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
